alu_arbiter: RTL

- Shares the single datapath ALU among NUM_REQ requesters (e.g. execute stage, branch comparator, address generator).
- Each requester presents operands and a 3-bit op over a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle, drives the ALU combinationally and registers the result into a one-entry response buffer.
- The response buffer is tagged with the requester ID and has its own valid/ready handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings and helpers used by every block that talks to the ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // SLT reports "true" as all ones except the sign bit.
  localparam logic [31:0] SLT_TRUE = 32'h7FFF_FFFF;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting just after last_grant and
// returns a one-hot grant plus its encoded index. Kept generic so other
// bus arbiters can reuse it.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   cand;
  logic found;

  // Priority scan from last_grant+1, wrapping modulo N; idx is valid even when
  // enable is low so callers can peek at the next winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    if (enable && found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters and buffers each result in a
// single tagged response slot.
//
// state | meaning
// EMPTY | rsp_valid=0, slot free, a grant may issue
// FULL  | rsp_valid=1, slot holds a result; refill allowed only with rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_control,
  output logic                 alu_rst,
  input  logic [31:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err
);

  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               can_issue;
  logic               granted;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [2:0]         sel_op;
  logic               sel_legal;

  // The slot can take a new result when empty or when it drains this cycle.
  assign can_issue = !rsp_valid || rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (can_issue && !rst),
    .gnt        (gnt),
    .idx        (gnt_idx)
  );

  assign granted   = |gnt;
  assign req_ready = gnt;

  // Operand mux keyed on the one-hot grant; idles at 0/0/ADD.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  assign sel_legal   = op_is_legal(sel_op);
  assign alu_a       = sel_a;
  assign alu_b       = sel_b;
  // Illegal codes never reach the ALU; it sees a harmless ADD instead.
  assign alu_control = (granted && sel_legal) ? sel_op : OP_ADD;
  assign alu_rst     = rst;
  assign rsp_zero    = (rsp_result == '0);

  // Response slot: capture on grant, otherwise drain when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (granted) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_idx;
      last_grant <= gnt_idx;
      rsp_result <= sel_legal ? alu_result : '0;
      rsp_err    <= !sel_legal;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
